fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock; one clock domain.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 imem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-005 imem_addr  output  32  byte address of request; valid when imem_req=1.
REQ-006 imem_rvalid  input  1  read data valid, one-cycle pulse, arrives 1 or more cycles after imem_req.
REQ-007 imem_rdata  input  32  instruction word; valid when imem_rvalid=1.
REQ-008 instruction  output  32  fetched word presented to the decode stage.
REQ-009 instr_pc  output  32  address of the presented instruction.
REQ-010 instr_valid  output  1  instruction/instr_pc hold a valid instruction.
REQ-011 instr_ready  input  1  decode accepts; transfer occurs when instr_valid and instr_ready are both 1.
REQ-012 redirect  input  1  taken branch/jump resolved this cycle.
REQ-013 redirect_pc  input  32  PC of the branch/jump instruction.
REQ-014 redirect_offset  input  32  sign-extended byte offset (decode branch_target format).
REQ-015 misalign  output  1  sticky flag: a redirect target had bits[1:0] nonzero.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and DROP, plus a 32-bit pc register.
REQ-017 IDLE SHALL move to REQ unconditionally on the next cycle.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; the next state SHALL be WAIT.
REQ-019 imem_req SHALL be 0 in every state except REQ; imem_addr SHALL equal pc in all states.
REQ-020 In WAIT with imem_rvalid=1, the block SHALL latch instruction<=imem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^32), and go to HOLD; with imem_rvalid=0 it SHALL stay in WAIT.
REQ-021 instr_valid SHALL be 1 exactly while the state is HOLD; instruction and instr_pc SHALL stay stable in HOLD.
REQ-022 In HOLD with instr_ready=1, the next state SHALL be REQ (next imem_req one cycle after the transfer); with instr_ready=0 it SHALL stay in HOLD.
REQ-023 redirect SHALL load pc<=(redirect_pc+redirect_offset) with bits[1:0] forced to 0, and SHALL set misalign if the unforced sum had bits[1:0] nonzero.
REQ-024 Redirect in HOLD SHALL go to REQ with no transfer, even if instr_ready=1 in the same cycle.
REQ-025 Redirect in REQ SHALL go to DROP, because the request just issued is stale.
REQ-026 Redirect in WAIT with imem_rvalid=1 SHALL discard the data and go to REQ.
REQ-027 Redirect in WAIT with imem_rvalid=0 SHALL go to DROP.
REQ-028 DROP SHALL discard the next imem_rvalid data without updating instruction or instr_pc, then go to REQ.
REQ-029 Redirect in DROP SHALL update pc and remain in DROP.
REQ-030 Redirect in IDLE SHALL update pc and proceed to REQ.
REQ-031 At most one imem request SHALL be outstanding at any time.
REQ-032 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.
REQ-033 redirect SHALL take priority over both the memory response and the handshake.

Reset
REQ-034 While rst=1 at a clock edge: state=IDLE, pc=RESET_PC, instruction=0, instr_pc=0, instr_valid=0, imem_req=0, misalign=0; if FETCH_PERF_EN, stall_count=0.
REQ-035 Reset mid-transaction SHALL abandon any outstanding request, and its late imem_rvalid SHALL be ignored (state IDLE).

Configuration
REQ-036 With macro FETCH_PERF_EN defined: add output stall_count (32-bit), incremented by 1 (wrapping) each cycle the state is WAIT or DROP.
REQ-037 Without FETCH_PERF_EN: port stall_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 Reset release, RESET_PC=0, memory latency 1, instr_ready=1 -> imem_req at addresses 0, 4, 8; instr_valid with instr_pc 0, 4, 8; instruction matches memory.
REQ-039 instr_ready held 0 for 5 cycles in HOLD -> instr_valid stays 1, instruction stable, no imem_req; instr_ready=1 -> imem_req on the next cycle at instr_pc+4.
REQ-040 redirect in HOLD with redirect_pc=0x10, offset=0xFFFF_FFF8 -> no transfer; next imem_addr=0x08.
REQ-041 redirect in REQ, memory latency 3 -> stale data dropped; next request at target; instr_pc=target.
REQ-042 redirect with redirect_pc=0x0, offset=0x6 -> imem_addr=0x4, misalign=1 until rst.
REQ-043 FETCH_PERF_EN with memory latency 4 over 3 instructions -> stall_count=12; rst mid-WAIT -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one outstanding imem read, a single-entry holding register toward decode, redirect-driven PC reload.
// Latency: request issued the cycle after IDLE/handshake/redirect; word presented one cycle after imem_rvalid.
// Backpressure: holds the word until instr_ready; optional stall counter under FETCH_PERF_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] redirect_offset,
    output logic        misalign
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target;

    always_comb begin
        target        = redirect_pc + redirect_offset;
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        misalign_d    = misalign_q | (redirect & (target[1:0] != 2'b00));

        if (redirect) begin
            pc_d = {target[31:2], 2'b00};
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ:  state_d = redirect ? DROP : WAIT;
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (redirect || instr_ready) begin
                    state_d = REQ;
                end
            end
            // A stale response landing together with a redirect still retires the
            // outstanding request, so waiting for another one would never end.
            DROP: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        imem_req_d    = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == WAIT || state_q == DROP) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;

endmodule
